// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector: pattern length up to MAX_LEN,
// optional overlapping matches, input qualifier and a saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0000_1011,
  parameter logic [LEN_W-1:0]   DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] shifted;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;

  // Lengths beyond the shift register are clamped; zero disables matching.
  assign eff_len  = (len_q > MAX_L) ? MAX_L : len_q;
  assign shifted  = {hist_q[MAX_LEN-2:0], in};
  assign fill_inc = (fill_q >= MAX_L) ? MAX_L : fill_q + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(eff_len));
    end
  end

  // fill guards the compare so the cleared history never fakes an all-zero match.
  assign hit = in_valid && !cfg_load && (eff_len != '0) && (fill_inc >= eff_len) &&
               (((shifted ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    cnt_d   = cnt_q;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = shifted;
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
    end
    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEF_PATTERN;
      len_q   <= DEF_LEN;
      ovl_q   <= DEF_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
      end
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: vector tables, hand-written corner sequences and a
// small reference model, all feeding one expected-value queue.
module tb_seq_detector_prog;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_b;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       match;
  logic [7:0] match_count;
  logic       match_s;
  logic [1:0] match_count_s;

  seq_detector_prog u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match), .match_count(match_count)
  );

  seq_detector_prog #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match_s), .match_count(match_count_s)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       b;
    logic       ld;
    logic       clr;
    logic       m;
    logic [7:0] c;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       use_small = 1'b0;

  // reference model state
  logic [7:0] m_h, m_pat;
  int         m_f, m_len, m_c;
  logic       m_ovl;

  // scoreboard
  task automatic check(input string name);
    logic [8:0] got, exp;
    got = use_small ? {match_s, 6'd0, match_count_s} : {match, match_count};
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: expected queue empty, got match=%0d count=%0d", name, got[8], got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got match=%0d count=%0d, expected match=%0d count=%0d",
                 name, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  // driver: inputs change 1 time unit after a rising edge, outputs sampled likewise
  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic [8:0] exp, input string name);
    in_valid = v; in_b = b; cfg_load = ld; cnt_clr = clr;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check(name);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 9'd0, name);
    rst = 1'b0;
    in_valid = 1'b0; in_b = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic add_vec(input logic v, input logic b, input logic ld, input logic clr,
                         input logic m, input logic [7:0] c);
    vec_t t;
    t.v = v; t.b = b; t.ld = ld; t.clr = clr; t.m = m; t.c = c;
    tbl.push_back(t);
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].clr, {tbl[i].m, tbl[i].c},
           $sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
  endtask

  task automatic mstep(input logic v, input logic b, input logic ld, input logic clr,
                       input string name);
    logic hit;
    hit = 1'b0;
    if (ld) begin
      m_h = '0; m_f = 0;
    end else if (v) begin
      m_h = {m_h[6:0], b};
      if (m_f < 8) m_f++;
      hit = (m_len != 0) && (m_f >= m_len) && (((m_h ^ m_pat) & (8'hFF >> (8 - m_len))) == 8'd0);
      if (hit && !m_ovl) m_f = 0;
    end
    if (clr) m_c = hit ? 1 : 0;
    else if (hit && m_c != 255) m_c++;
    step(v, b, ld, clr, {hit, 8'(m_c)}, name);
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_b = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    set_cfg(8'd0, 4'd0, 1'b0);
    do_reset("reset0");
    do_reset("reset1");

    // default 1011, non-overlapping: one match, then fill restarts
    add_vec(1,1,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,1,0,0, 0,0);
    add_vec(1,1,0,0, 1,1); add_vec(1,0,0,0, 0,1); add_vec(1,1,0,0, 0,1);
    add_vec(1,1,0,0, 0,1); add_vec(0,0,0,0, 0,1);
    run_tbl("dflt");

    // pattern 101 overlap: two matches on 10101
    set_cfg(8'b0000_0101, 4'd3, 1'b1);
    add_vec(0,0,1,1, 0,0);
    add_vec(1,1,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,1,0,0, 1,1);
    add_vec(1,0,0,0, 0,1); add_vec(1,1,0,0, 1,2);
    run_tbl("ovl1");

    // non-overlap: one match; load also keeps the count when cnt_clr is low
    set_cfg(8'b0000_0101, 4'd3, 1'b0);
    add_vec(0,0,1,0, 0,2); add_vec(0,0,0,1, 0,0);
    add_vec(1,1,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,1,0,0, 1,1);
    add_vec(1,0,0,0, 0,1); add_vec(1,1,0,0, 0,1);
    run_tbl("ovl0");

    // bit presented with cfg_load is discarded, so 0,1 afterwards is no match
    add_vec(1,1,1,0, 0,1); add_vec(1,0,0,0, 0,1); add_vec(1,1,0,0, 0,1);
    add_vec(1,0,0,0, 0,1); add_vec(1,1,0,0, 1,2);
    run_tbl("ld_discard");

    // 1011 with 5-cycle idle gaps carrying random data
    set_cfg(8'b0000_1011, 4'd4, 1'b0);
    step(0, 0, 1, 1, 9'd0, "gap_load");
    for (int i = 0; i < 4; i++) begin
      logic [3:0] pat;
      pat = 4'b1011;
      step(1, pat[3-i], 0, 0, (i == 3) ? {1'b1, 8'd1} : 9'd0, $sformatf("gap_bit%0d", i));
      for (int g = 0; g < 5; g++) begin
        step(0, 1'($urandom_range(0, 1)), 0, 0, (i == 3) ? 9'd1 : 9'd0,
             $sformatf("gap_idle%0d_%0d", i, g));
      end
    end

    // length 0 disables the detector
    set_cfg(8'd0, 4'd0, 1'b1);
    step(0, 0, 1, 1, 9'd0, "len0_load");
    for (int i = 0; i < 64; i++) begin
      step(1, 1'($urandom_range(0, 1)), 0, 0, 9'd0, $sformatf("len0[%0d]", i));
    end

    // length 15 clamps to 8: only the full 8-bit pattern matches
    set_cfg(8'b1100_1010, 4'd15, 1'b0);
    step(0, 0, 1, 1, 9'd0, "len15_load");
    begin
      logic [11:0] s;
      s = 12'b1010_1100_1010;
      for (int i = 0; i < 12; i++) begin
        step(1, s[11-i], 0, 0, (i == 11) ? {1'b1, 8'd1} : 9'd0, $sformatf("len15[%0d]", i));
      end
    end

    // random stream against the reference model, both overlap modes
    for (int o = 0; o < 2; o++) begin
      set_cfg(8'b1010_0110, 4'd4, 1'(o));
      m_pat = 8'b1010_0110; m_len = 4; m_ovl = 1'(o); m_c = 0; m_h = '0; m_f = 0;
      mstep(0, 0, 1, 1, $sformatf("rnd%0d_load", o));
      for (int i = 0; i < 120; i++) begin
        mstep(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 0,
              1'($urandom_range(0, 40) == 0), $sformatf("rnd%0d[%0d]", o, i));
      end
    end

    // 2-bit counter saturation and cnt_clr coinciding with a match
    use_small = 1'b1;
    set_cfg(8'b0000_0001, 4'd1, 1'b1);
    add_vec(0,0,1,1, 0,0);
    add_vec(1,1,0,0, 1,1); add_vec(1,1,0,0, 1,2); add_vec(1,1,0,0, 1,3);
    add_vec(1,1,0,0, 1,3); add_vec(1,1,0,1, 1,1); add_vec(0,1,0,1, 0,0);
    add_vec(1,0,0,0, 0,0);
    run_tbl("sat");
    use_small = 1'b0;

    // reset mid-pattern discards partial history
    do_reset("mid_rst0");
    add_vec(1,1,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,1,0,0, 0,0);
    run_tbl("mid_pre");
    do_reset("mid_rst1");
    add_vec(1,1,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,1,0,0, 0,0);
    add_vec(1,1,0,0, 1,1);
    run_tbl("mid_post");

    // all-zero pattern right after reset needs four zero bits
    do_reset("zero_rst");
    set_cfg(8'd0, 4'd4, 1'b0);
    add_vec(0,0,1,0, 0,0);
    add_vec(1,0,0,0, 0,0); add_vec(1,0,0,0, 0,0); add_vec(1,0,0,0, 0,0);
    add_vec(1,0,0,0, 1,1); add_vec(1,0,0,0, 0,1);
    run_tbl("zero");

    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-pattern detector with pattern length up to MAX_LEN, overlapping or non-overlapping match mode, input qualifier and saturating match counter.
- Generalises the fixed 4-bit "1011" detector. Sits on a serial data path; the match pulse feeds interrupt/event logic and the count is read by software.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of the length field; must hold MAX_LEN.
- CNT_W, 8, match counter width.
- DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits).
- DEF_LEN, 4, length loaded at reset.
- DEF_OVERLAP, 0, overlap mode loaded at reset.

Ports:
- clk, input, 1, sole clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, qualifies in; a bit is consumed only when high.
- in, input, 1, serial data bit.
- cfg_load, input, 1, one-cycle strobe that latches cfg_* and restarts matching.
- cfg_pattern, input, MAX_LEN, pattern. Bit [len-1] is the first bit received; bit [0] is the most recent.
- cfg_len, input, LEN_W, pattern length.
- cfg_overlap, input, 1, 1 = overlapping matches allowed.
- cnt_clr, input, 1, clears match_count.
- match, output, 1, registered one-cycle pulse per detected pattern.
- match_count, output, CNT_W, saturating count of matches.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - history=0, fill=0, match=0, match_count=0.
  - Pattern, length and overlap registers load DEF_PATTERN, DEF_LEN and DEF_OVERLAP.
  - rst overrides every other input.
- Internal state:
  - history: MAX_LEN-bit shift register, {history[MAX_LEN-2:0], in} on each accepted bit.
  - fill: count of valid bits held, saturating at MAX_LEN.
- Effective length L:
  - cfg_len = 0 means the detector is disabled: match never asserts and the counter holds.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
- Match condition, evaluated on the updated history for an accepted bit: fill >= L and history[L-1:0] == pattern[L-1:0].
- Latency: match goes high in the cycle after the edge that accepts the completing bit and lasts exactly one cycle. It is 0 in any cycle with no accepted bit.
- Overlap mode 1: history and fill are untouched after a match, so the suffix can start the next match. Pattern 101 on stream 10101 gives 2 matches.
- Overlap mode 0: fill is cleared to 0 on a match, and the next match needs L fresh bits. Stream 10101 with pattern 101 gives 1 match.
- in_valid=0: history, fill and the matcher are frozen. Gaps of any length between bits do not break a match.
- cfg_load=1:
  - Latches all cfg_*, clears history and fill, and forces match=0 next cycle.
  - A bit presented in the same cycle is discarded.
  - match_count is not affected.
- Counter:
  - Increments by 1 per match and saturates at 2^CNT_W-1; it never wraps.
  - cnt_clr alone sets it to 0.
  - cnt_clr and a match in the same cycle set it to 1.
  - A match at saturation leaves it saturated.
- Reset mid-pattern: partial history is discarded, and no match occurs until L new bits arrive.
- Matching starts only after fill reaches L, so zeros in the cleared history never produce a false match for an all-zero pattern.

Test Plan:
- Default config after reset, stream 1,0,1,1,0,1,1 (in_valid=1): match pulses once, 1 cycle after the 4th bit; fill then restarts (overlap 0), so bits 5-7 give no match; match_count=1.
- cfg_load pattern=101, L=3, overlap=1; stream 1,0,1,0,1: matches after bits 3 and 5, count=2. Repeat with overlap=0: one match after bit 3, count=1.
- Default 1011 with in_valid low for 5 cycles between every bit: match still pulses 1 cycle after the 4th accepted bit; no pulses during the gaps.
- cfg_len=0, then random 64-bit stream: match stays 0 and count stays 0. cfg_len=15 with MAX_LEN=8 behaves as L=8: an 8-bit pattern matches.
- CNT_W=2, L=1, pattern=1, overlap=1, ones stream: count goes 1,2,3 and holds at 3. cnt_clr asserted in a match cycle gives count 1.
- Stream 1,0,1 then rst for 1 cycle, then 1: no match; the following 0,1,1 (4 bits total after reset) gives 1 match. An all-zero pattern with L=4 right after reset needs 4 zero bits before matching.
